// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory with a fixed
// read latency. Serialises accesses and returns read data with an rvalid pulse.
module mem_port_arbiter #(
  parameter int word_size = 16,
  parameter int addr_size = 16,
  parameter int rd_lat    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p0_req,
  input  logic                 p0_we,
  input  logic [addr_size-1:0] p0_addr,
  input  logic [word_size-1:0] p0_wdata,
  output logic                 p0_gnt,
  output logic                 p0_rvalid,
  output logic [word_size-1:0] p0_rdata,
  input  logic                 p1_req,
  input  logic                 p1_we,
  input  logic [addr_size-1:0] p1_addr,
  input  logic [word_size-1:0] p1_wdata,
  output logic                 p1_gnt,
  output logic                 p1_rvalid,
  output logic [word_size-1:0] p1_rdata,
  output logic [addr_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_wdata,
  output logic                 mem_write,
  input  logic [word_size-1:0] mem_rdata,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [3:0] cnt_load = 4'(rd_lat - 1);

  state_t               state, state_nx;
  logic                 last_winner, last_winner_nx;
  logic                 winner, winner_nx;
  logic                 we_q, we_nx;
  logic [3:0]           cnt, cnt_nx;
  logic [1:0]           gnt_q, gnt_nx;
  logic [1:0]           rvalid_q, rvalid_nx;
  logic [addr_size-1:0] addr_nx;
  logic [word_size-1:0] wdata_nx;
  logic                 write_nx;
  logic                 busy_nx;
  logic [word_size-1:0] rdata0_nx, rdata1_nx;
  logic                 sel;

  // Every output is the registered image of the next-state logic, so grant,
  // write strobe and address all appear together in the ISSUE cycle.
  always_comb begin
    state_nx       = state;
    last_winner_nx = last_winner;
    winner_nx      = winner;
    we_nx          = we_q;
    cnt_nx         = cnt;
    gnt_nx         = '0;
    rvalid_nx      = '0;
    addr_nx        = mem_addr;
    wdata_nx       = mem_wdata;
    write_nx       = 1'b0;
    rdata0_nx      = p0_rdata;
    rdata1_nx      = p1_rdata;
    sel            = 1'b0;

    case (state)
      IDLE: begin
        if (p0_req || p1_req) begin
          if (p0_req && p1_req) sel = ~last_winner;
          else                  sel = p1_req;
          winner_nx      = sel;
          last_winner_nx = sel;
          we_nx          = sel ? p1_we    : p0_we;
          addr_nx        = sel ? p1_addr  : p0_addr;
          wdata_nx       = sel ? p1_wdata : p0_wdata;
          write_nx       = sel ? p1_we    : p0_we;
          gnt_nx[sel]    = 1'b1;
          state_nx       = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_nx = IDLE;
        end else begin
          state_nx = WAIT;
          cnt_nx   = cnt_load;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nx          = IDLE;
          rvalid_nx[winner] = 1'b1;
          if (winner) rdata1_nx = mem_rdata;
          else        rdata0_nx = mem_rdata;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_winner <= 1'b1;
      winner      <= 1'b0;
      we_q        <= 1'b0;
      cnt         <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_write   <= 1'b0;
      busy        <= 1'b0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
    end else begin
      state       <= state_nx;
      last_winner <= last_winner_nx;
      winner      <= winner_nx;
      we_q        <= we_nx;
      cnt         <= cnt_nx;
      gnt_q       <= gnt_nx;
      rvalid_q    <= rvalid_nx;
      mem_addr    <= addr_nx;
      mem_wdata   <= wdata_nx;
      mem_write   <= write_nx;
      busy        <= busy_nx;
      p0_rdata    <= rdata0_nx;
      p1_rdata    <= rdata1_nx;
    end
  end

  assign p0_gnt    = gnt_q[0];
  assign p1_gnt    = gnt_q[1];
  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (rd_lat 1 and 3), a timestamp-based
// transaction model checked every cycle, plus directed literal expectations.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  req_s [2];
  logic [1:0]  we_s  [2];
  logic [1:0]  gnt_s [2];
  logic [1:0]  rv_s  [2];
  logic [15:0] addr_s [2][2];
  logic [15:0] wd_s   [2][2];
  logic [15:0] rd_s   [2][2];
  logic [15:0] maddr_s [2];
  logic [15:0] mwd_s   [2];
  logic [15:0] mrd_s   [2];
  logic        mw_s    [2];
  logic        busy_s  [2];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  generate
    for (genvar k = 0; k < 2; k++) begin : g
      localparam int LAT = (k == 0) ? 1 : 3;
      logic [15:0] mem  [256];
      logic [15:0] pipe [LAT];
      bit          mem_ready = 1'b0;

      mem_port_arbiter #(
        .word_size(16),
        .addr_size(16),
        .rd_lat(LAT)
      ) dut (
        .clk      (clk),
        .rst      (rst),
        .p0_req   (req_s[k][0]),
        .p0_we    (we_s[k][0]),
        .p0_addr  (addr_s[k][0]),
        .p0_wdata (wd_s[k][0]),
        .p0_gnt   (gnt_s[k][0]),
        .p0_rvalid(rv_s[k][0]),
        .p0_rdata (rd_s[k][0]),
        .p1_req   (req_s[k][1]),
        .p1_we    (we_s[k][1]),
        .p1_addr  (addr_s[k][1]),
        .p1_wdata (wd_s[k][1]),
        .p1_gnt   (gnt_s[k][1]),
        .p1_rvalid(rv_s[k][1]),
        .p1_rdata (rd_s[k][1]),
        .mem_addr (maddr_s[k]),
        .mem_wdata(mwd_s[k]),
        .mem_write(mw_s[k]),
        .mem_rdata(mrd_s[k]),
        .busy     (busy_s[k])
      );

      // Memory with LAT register stages between address and read data.
      always @(posedge clk) begin
        if (!mem_ready) begin
          for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
          mem[16]   <= 16'hBEEF;
          mem[48]   <= 16'hCAFE;
          mem_ready <= 1'b1;
        end else if (mw_s[k]) begin
          mem[maddr_s[k][7:0]] <= mwd_s[k];
        end
        pipe[0] <= mem[maddr_s[k][7:0]];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
      assign mrd_s[k] = pipe[LAT-1];
    end
  endgenerate

  // Transaction model: an accepted access occupies the arbiter until a known
  // cycle; read data and rvalid are scheduled at an absolute cycle number.
  int          cyc = 0;
  int          idle_from [2];
  logic        lastw  [2];
  logic        rdp    [2];
  logic        rdport [2];
  int          rdcyc  [2];
  logic [15:0] rddat  [2];
  logic [15:0] shadow [2][256];
  bit          shadow_init = 1'b0;
  logic        mw_w;
  logic [1:0]  e_gnt [2];
  logic [1:0]  e_rv  [2];
  logic [15:0] e_rd  [2][2];
  logic [15:0] e_addr [2];
  logic [15:0] e_wd   [2];
  logic        e_we   [2];
  logic        e_busy [2];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (!shadow_init) begin
      for (int k = 0; k < 2; k++) begin
        for (int a = 0; a < 256; a++) shadow[k][a] = 16'h0000;
        shadow[k][16] = 16'hBEEF;
        shadow[k][48] = 16'hCAFE;
      end
      shadow_init = 1'b1;
    end
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        idle_from[k] = 0;
        lastw[k]     = 1'b1;
        rdp[k]       = 1'b0;
        e_gnt[k]     = 2'b00;
        e_rv[k]      = 2'b00;
        e_rd[k][0]   = 16'h0000;
        e_rd[k][1]   = 16'h0000;
        e_addr[k]    = 16'h0000;
        e_wd[k]      = 16'h0000;
        e_we[k]      = 1'b0;
        e_busy[k]    = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        e_gnt[k] = 2'b00;
        e_rv[k]  = 2'b00;
        e_we[k]  = 1'b0;
        if (rdp[k] && (cyc + 1 == rdcyc[k])) begin
          e_rv[k][rdport[k]] = 1'b1;
          e_rd[k][rdport[k]] = rddat[k];
          rdp[k] = 1'b0;
        end
        if (cyc >= idle_from[k] && req_s[k] != 2'b00) begin
          mw_w = (req_s[k] == 2'b11) ? ~lastw[k] : req_s[k][1];
          lastw[k] = mw_w;
          e_gnt[k][mw_w] = 1'b1;
          e_addr[k] = addr_s[k][mw_w];
          e_wd[k]   = wd_s[k][mw_w];
          e_we[k]   = we_s[k][mw_w];
          if (we_s[k][mw_w]) begin
            shadow[k][addr_s[k][mw_w][7:0]] = wd_s[k][mw_w];
            idle_from[k] = cyc + 2;
          end else begin
            rdp[k]    = 1'b1;
            rdport[k] = mw_w;
            rdcyc[k]  = cyc + 2 + lat_of(k);
            rddat[k]  = shadow[k][addr_s[k][mw_w][7:0]];
            idle_from[k] = cyc + 2 + lat_of(k);
          end
        end
        e_busy[k] = (cyc + 1 < idle_from[k]);
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("cycle_outputs inst%0d t=%0t", k, $time),
          {gnt_s[k], rv_s[k], rd_s[k][0], rd_s[k][1], maddr_s[k], mwd_s[k], mw_s[k], busy_s[k]},
          {e_gnt[k], e_rv[k], e_rd[k][0], e_rd[k][1], e_addr[k], e_wd[k], e_we[k], e_busy[k]});
    end
  end

  // Observation counters used by the directed literal checks.
  int gq[$];
  int wcount = 0, bcount1 = 0, rv0count = 0, ncyc = 0, g1cyc = 0, r1cyc = 0;
  always @(negedge clk) begin
    ncyc++;
    if (gnt_s[0][0]) gq.push_back(0);
    if (gnt_s[0][1]) gq.push_back(1);
    if (mw_s[0])     wcount++;
    if (rv_s[0][0])  rv0count++;
    if (busy_s[1])   bcount1++;
    if (gnt_s[1] != 2'b00) g1cyc = ncyc;
    if (rv_s[1] != 2'b00)  r1cyc = ncyc;
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise a request at posedge+1, hold until gnt, drop it the cycle after.
  task automatic issue(input int k, input int p, input logic we, input logic [15:0] a,
                       input logic [15:0] d);
    bit got;
    got = 1'b0;
    req_s[k][p]  = 1'b1;
    we_s[k][p]   = we;
    addr_s[k][p] = a;
    wd_s[k][p]   = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt_s[k][p]) begin
        got = 1'b1;
        break;
      end
    end
    chk($sformatf("gnt_seen inst%0d port%0d", k, p), got, 1'b1);
    @(posedge clk);
    #1;
    req_s[k][p] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  int base, wb, rvb, bb;

  initial begin
    for (int k = 0; k < 2; k++) begin
      req_s[k] = 2'b00;
      we_s[k]  = 2'b00;
      for (int p = 0; p < 2; p++) begin
        addr_s[k][p] = 16'h0000;
        wd_s[k][p]   = 16'h0000;
      end
    end
    rst = 1'b1;
    cyc_wait(3);
    chk("reset_busy", busy_s[0], 1'b0);
    chk("reset_addr", maddr_s[0], 16'h0000);
    chk("reset_gnt_rv", {gnt_s[0], rv_s[0], mw_s[0]}, 5'b0);
    rst = 1'b0;

    // Single p0 read of 0x0010 (holds 0xBEEF): gnt cycle 2, rvalid cycle 4.
    cyc_wait(1);
    req_s[0][0] = 1'b1; we_s[0][0] = 1'b0; addr_s[0][0] = 16'h0010;
    @(negedge clk);
    chk("c1_no_gnt", gnt_s[0], 2'b00);
    @(negedge clk);
    chk("c2_p0_gnt", gnt_s[0], 2'b01);
    chk("c2_addr", maddr_s[0], 16'h0010);
    chk("c2_no_write", mw_s[0], 1'b0);
    @(posedge clk); #1;
    req_s[0][0] = 1'b0;
    @(negedge clk);
    chk("c3_addr_held", maddr_s[0], 16'h0010);
    chk("c3_busy", busy_s[0], 1'b1);
    @(negedge clk);
    chk("c4_p0_rvalid", rv_s[0], 2'b01);
    chk("c4_p0_rdata", rd_s[0][0], 16'hBEEF);
    @(negedge clk);
    chk("c5_rdata_held", {rv_s[0], rd_s[0][0]}, {2'b00, 16'hBEEF});
    cyc_wait(1);

    // p1 write then p0 read-back.
    wb = wcount;
    issue(0, 1, 1'b1, 16'h0020, 16'h1234);
    issue(0, 0, 1'b0, 16'h0020, 16'h0000);
    cyc_wait(5);
    chk("p1_write_once", wcount - wb, 1);
    chk("readback_0020", rd_s[0][0], 16'h1234);

    // Both ports requesting continuously after reset: p0, p1, p0, p1.
    rst = 1'b1;
    cyc_wait(2);
    rst = 1'b0;
    cyc_wait(1);
    base = gq.size();
    fork
      begin
        issue(0, 0, 1'b0, 16'h0010, 16'h0000);
        issue(0, 0, 1'b0, 16'h0030, 16'h0000);
      end
      begin
        issue(0, 1, 1'b0, 16'h0020, 16'h0000);
        issue(0, 1, 1'b0, 16'h0010, 16'h0000);
      end
    join
    cyc_wait(6);
    chk("rr_count", gq.size() - base, 4);
    if (gq.size() - base == 4) begin
      chk("rr_order0", gq[base],   0);
      chk("rr_order1", gq[base+1], 1);
      chk("rr_order2", gq[base+2], 0);
      chk("rr_order3", gq[base+3], 1);
    end
    chk("rr_p1_last_rdata", rd_s[0][1], 16'hBEEF);

    // Async reset during WAIT of a p0 read.
    req_s[0][0] = 1'b1; we_s[0][0] = 1'b0; addr_s[0][0] = 16'h0030;
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (gnt_s[0][0]) begin
          got = 1'b1;
          break;
        end
      end
      chk("rst_test_gnt", got, 1'b1);
    end
    @(posedge clk); #1;
    req_s[0][0] = 1'b0;
    #1 rst = 1'b1;
    rvb = rv0count;
    #1;
    chk("async_rst_ctrl", {gnt_s[0], rv_s[0], mw_s[0], busy_s[0]}, 6'b0);
    chk("async_rst_addr", maddr_s[0], 16'h0000);
    chk("async_rst_rdata", {rd_s[0][0], rd_s[0][1]}, 32'h0);
    cyc_wait(2);
    rst = 1'b0;
    cyc_wait(1);
    base = gq.size();
    fork
      issue(0, 0, 1'b1, 16'h0050, 16'h7777);
      issue(0, 1, 1'b0, 16'h0050, 16'h0000);
    join
    cyc_wait(6);
    chk("post_rst_no_p0_rvalid", rv0count - rvb, 0);
    chk("post_rst_first_p0", (gq.size() > base) ? gq[base] : -1, 0);
    chk("post_rst_p1_rdata", rd_s[0][1], 16'h7777);

    // p0 write immediately followed by p0 read of the same address.
    wb = wcount;
    issue(0, 0, 1'b1, 16'h0040, 16'h5A5A);
    issue(0, 0, 1'b0, 16'h0040, 16'h0000);
    cyc_wait(6);
    chk("wr_rd_one_write", wcount - wb, 1);
    chk("wr_rd_data", rd_s[0][0], 16'h5A5A);

    // rd_lat = 3 instance, p1 read of 0x0030.
    bb = bcount1;
    issue(1, 1, 1'b0, 16'h0030, 16'h0000);
    cyc_wait(8);
    chk("lat3_busy_cycles", bcount1 - bb, 4);
    chk("lat3_gnt_to_rvalid", r1cyc - g1cyc, 4);
    chk("lat3_rdata", rd_s[1][1], 16'hCAFE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
